// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: sequential fetch addressing, instruction-memory
// read handshake, a small prefetch FIFO feeding ID, and branch/jump redirects
// that preserve the single MIPS delay slot.
// Optional build macro: IF_PERF_CNT_EN adds fetch/redirect/flush counters.
module inst_fetch_unit #(
  parameter int                 DATA_W     = 32,
  parameter logic [DATA_W-1:0]  RESET_PC   = '0,
  parameter int                 FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] inst_address,
  output logic              InstMem_Read,
  input  logic              InstMem_Ready,
  input  logic [DATA_W-1:0] inst_in,
  input  logic              redirect_valid,
  input  logic [DATA_W-1:0] redirect_pc,
  input  logic              id_stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_inst,
  output logic [DATA_W-1:0] if_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_redirect_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    RUN,
    DSLOT_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   fpc_q, fpc_d;
  logic [DATA_W-1:0]   target_q, target_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   pc_mem_q   [FIFO_DEPTH];
  logic [DATA_W-1:0]   inst_mem_q [FIFO_DEPTH];

  logic                accept;
  logic                pop;
  logic [DATA_W-1:0]   redirect_aligned;

  // Targets are always word aligned; low two bits are dropped.
  assign redirect_aligned = redirect_pc & ~DATA_W'(3);

  // A same-cycle pop does not make room for a new request.
  assign InstMem_Read = !rst && (count_q < CNT_W'(FIFO_DEPTH)) && !redirect_valid;
  assign inst_address = fpc_q;
  assign accept       = InstMem_Read && InstMem_Ready;

  assign if_valid = (count_q != '0);
  assign pop      = if_valid && !id_stall;
  assign if_inst  = if_valid ? inst_mem_q[rd_ptr_q] : '0;
  assign if_pc    = if_valid ? pc_mem_q[rd_ptr_q]   : '0;

  // Next-state: FIFO bookkeeping, fetch PC advance and redirect handling.
  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    target_d = target_q;
    rd_ptr_d = pop    ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          if (count_q != '0) begin
            // Head is the delay slot: keep it, drop everything behind it.
            wr_ptr_d = rd_ptr_q + 1'b1;
            count_d  = pop ? CNT_W'(0) : CNT_W'(1);
            fpc_d    = redirect_aligned;
          end else begin
            // Delay slot not fetched yet: fetch it first, then the target.
            target_d = redirect_aligned;
            state_d  = DSLOT_WAIT;
          end
        end else if (accept) begin
          fpc_d = fpc_q + DATA_W'(4);
        end
      end
      DSLOT_WAIT: begin
        // A redirect here is illegal and has no effect on state.
        if (accept) begin
          fpc_d   = target_q;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      fpc_q    <= RESET_PC;
      target_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      target_q <= target_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Prefetch storage: write the accepted beat with its fetch PC.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_mem_q[wr_ptr_q]   <= fpc_q;
      inst_mem_q[wr_ptr_q] <= inst_in;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic redirect_legal;
  assign redirect_legal = redirect_valid && (state_q == RUN);

  // Performance counters: accepted beats, legal redirects, flushed entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt    <= '0;
      perf_redirect_cnt <= '0;
      perf_flush_cnt    <= '0;
    end else begin
      if (accept) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (redirect_legal) begin
        perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
      end
      if (redirect_legal && (count_q != '0)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'(count_q - 1'b1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: scoreboard of delivered (pc, inst)
// pairs plus inline cycle checks for each scenario.
module tb_inst_fetch_unit;
  localparam int          DATA_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_address;
  logic        InstMem_Read;
  logic        InstMem_Ready;
  logic [31:0] inst_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_redirect_cnt, perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [63:0] ent(input logic [31:0] pc);
    return {pc, mem_word(pc)};
  endfunction

  assign inst_in = mem_word(inst_address);

  inst_fetch_unit #(
    .DATA_W(DATA_W), .RESET_PC(RESET_PC), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .inst_address(inst_address), .InstMem_Read(InstMem_Read),
    .InstMem_Ready(InstMem_Ready), .inst_in(inst_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_stall(id_stall),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt), .perf_redirect_cnt(perf_redirect_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  int checks = 0;
  int passed = 0;

  // Record every delivery to ID; one line per transaction.
  always @(negedge clk) begin
    if (!rst && if_valid && !id_stall) begin
      got_q.push_back({if_pc, if_inst});
      $display("[%0t] deliver pc=%h inst=%h", $time, if_pc, if_inst);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; InstMem_Ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; id_stall = 1'b0;
    @(posedge clk);
    step();
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; InstMem_Ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = '0; id_stall = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++; if (InstMem_Read !== 1'b0) $display("FAIL reset_read got %b exp 0", InstMem_Read); else passed++;
    checks++; if (if_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", if_valid); else passed++;
    checks++; if (inst_address !== RESET_PC) $display("FAIL reset_addr got %h exp %h", inst_address, RESET_PC); else passed++;
    checks++; if (if_pc !== 32'h0) $display("FAIL reset_if_pc got %h exp 0", if_pc); else passed++;
    checks++; if (if_inst !== 32'h0) $display("FAIL reset_if_inst got %h exp 0", if_inst); else passed++;
  endtask

  task automatic test_sequential();
    logic [63:0] e, g;
    apply_reset();
    InstMem_Ready = 1'b1;
    for (int k = 0; k < 7; k++) exp_q.push_back(ent(32'(4 * k)));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (inst_address !== 32'(4 * k) || InstMem_Read !== 1'b1)
        $display("FAIL seq_addr cycle %0d got %h/%b exp %h/1", k, inst_address, InstMem_Read, 32'(4 * k)); else passed++;
      if (k == 0) begin
        checks++; if (if_valid !== 1'b0) $display("FAIL seq_first_valid got %b exp 0", if_valid); else passed++;
      end
      if (k == 1) begin
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) $display("FAIL seq_latency got %b/%h exp 1/0", if_valid, if_pc); else passed++;
      end
    end
    step(); id_stall = 1'b1; InstMem_Ready = 1'b0;
    checks++; if (got_q.size() !== exp_q.size()) $display("FAIL seq_count got %0d exp %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL seq_deliver got %h exp %h", g, e); else passed++;
    end
  endtask

  task automatic test_stall();
    logic [63:0] e, g;
    apply_reset();
    InstMem_Ready = 1'b1; id_stall = 1'b1;
    exp_q.push_back(ent(32'h0)); exp_q.push_back(ent(32'h4));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        checks++; if (InstMem_Read !== 1'b0 || inst_address !== 32'h8 || if_pc !== 32'h0)
          $display("FAIL stall_full cycle %0d got read=%b addr=%h pc=%h exp 0/8/0", k, InstMem_Read, inst_address, if_pc); else passed++;
      end
    end
    step(); id_stall = 1'b0;
    @(negedge clk);
    checks++; if (if_pc !== 32'h0 || InstMem_Read !== 1'b0) $display("FAIL stall_rel0 got pc=%h read=%b exp 0/0", if_pc, InstMem_Read); else passed++;
    @(negedge clk);
    checks++; if (if_pc !== 32'h4 || InstMem_Read !== 1'b1) $display("FAIL stall_rel1 got pc=%h read=%b exp 4/1", if_pc, InstMem_Read); else passed++;
    step(); id_stall = 1'b1; InstMem_Ready = 1'b0;
    checks++; if (got_q.size() !== exp_q.size()) $display("FAIL stall_count got %0d exp %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL stall_deliver got %h exp %h", g, e); else passed++;
    end
  endtask

  task automatic test_latency();
    logic [63:0] e, g;
    apply_reset();
    InstMem_Ready = 1'b1;
    for (int k = 0; k < 5; k++) exp_q.push_back(ent(32'(4 * k)));
    repeat (4) @(posedge clk);
    #1; InstMem_Ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (inst_address !== 32'h10 || InstMem_Read !== 1'b1)
        $display("FAIL lat_hold cycle %0d got %h/%b exp 10/1", k, inst_address, InstMem_Read); else passed++;
      if (k == 2) begin
        checks++; if (if_valid !== 1'b0) $display("FAIL lat_nopush got %b exp 0", if_valid); else passed++;
      end
    end
    step(); InstMem_Ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (if_pc !== 32'h10 || inst_address !== 32'h14) $display("FAIL lat_accept got pc=%h addr=%h exp 10/14", if_pc, inst_address); else passed++;
    step(); id_stall = 1'b1; InstMem_Ready = 1'b0;
    checks++; if (got_q.size() !== exp_q.size()) $display("FAIL lat_count got %0d exp %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL lat_deliver got %h exp %h", g, e); else passed++;
    end
  endtask

  task automatic test_redirect_full();
    logic [63:0] e, g;
    apply_reset();
    InstMem_Ready = 1'b1;
    exp_q.push_back(ent(32'h0)); exp_q.push_back(ent(32'h4));
    exp_q.push_back(ent(32'h8)); exp_q.push_back(ent(32'h40));
    repeat (3) @(posedge clk);
    #1; id_stall = 1'b1;
    step(); id_stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || InstMem_Read !== 1'b0)
      $display("FAIL rdf_dslot got %b/%h/%b exp 1/8/0", if_valid, if_pc, InstMem_Read); else passed++;
    step(); redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (inst_address !== 32'h40 || InstMem_Read !== 1'b1 || if_valid !== 1'b0)
      $display("FAIL rdf_target got %h/%b/%b exp 40/1/0", inst_address, InstMem_Read, if_valid); else passed++;
    @(negedge clk);
    checks++; if (if_pc !== 32'h40) $display("FAIL rdf_next got %h exp 40", if_pc); else passed++;
    step(); id_stall = 1'b1; InstMem_Ready = 1'b0;
    checks++; if (got_q.size() !== exp_q.size()) $display("FAIL rdf_count got %0d exp %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL rdf_deliver got %h exp %h", g, e); else passed++;
    end
  endtask

  task automatic test_redirect_empty();
    logic [63:0] e, g;
    apply_reset();
    InstMem_Ready = 1'b1;
    for (int k = 0; k < 9; k++) exp_q.push_back(ent(32'(4 * k)));
    exp_q.push_back(ent(32'h100));
    repeat (8) @(posedge clk);
    #1; InstMem_Ready = 1'b0;
    step(); redirect_valid = 1'b1; redirect_pc = 32'h103; InstMem_Ready = 1'b1;
    @(negedge clk);
    checks++; if (InstMem_Read !== 1'b0 || inst_address !== 32'h20 || if_valid !== 1'b0)
      $display("FAIL rde_cycle got %b/%h/%b exp 0/20/0", InstMem_Read, inst_address, if_valid); else passed++;
    step(); redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (InstMem_Read !== 1'b1 || inst_address !== 32'h20 || if_valid !== 1'b0)
      $display("FAIL rde_dslot_fetch got %b/%h/%b exp 1/20/0", InstMem_Read, inst_address, if_valid); else passed++;
    @(negedge clk);
    checks++; if (inst_address !== 32'h100 || if_pc !== 32'h20)
      $display("FAIL rde_target_fetch got addr=%h pc=%h exp 100/20", inst_address, if_pc); else passed++;
    @(negedge clk);
    checks++; if (if_pc !== 32'h100 || inst_address !== 32'h104)
      $display("FAIL rde_target_deliver got pc=%h addr=%h exp 100/104", if_pc, inst_address); else passed++;
    step(); id_stall = 1'b1; InstMem_Ready = 1'b0;
    checks++; if (got_q.size() !== exp_q.size()) $display("FAIL rde_count got %0d exp %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL rde_deliver got %h exp %h", g, e); else passed++;
    end
  endtask

  task automatic test_wrap();
    logic [63:0] e, g;
    apply_reset();
    InstMem_Ready = 1'b1;
    exp_q.push_back(ent(32'h0)); exp_q.push_back(ent(32'hFFFF_FFFC)); exp_q.push_back(ent(32'h0));
    step(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    checks++; if (InstMem_Read !== 1'b0 || if_pc !== 32'h0) $display("FAIL wrap_redir got %b/%h exp 0/0", InstMem_Read, if_pc); else passed++;
    step(); redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (inst_address !== 32'hFFFF_FFFC) $display("FAIL wrap_top got %h exp fffffffc", inst_address); else passed++;
    @(negedge clk);
    checks++; if (inst_address !== 32'h0 || if_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_roll got %h/%h exp 0/fffffffc", inst_address, if_pc); else passed++;
    @(negedge clk);
    checks++; if (inst_address !== 32'h4 || if_pc !== 32'h0) $display("FAIL wrap_next got %h/%h exp 4/0", inst_address, if_pc); else passed++;
    step(); id_stall = 1'b1; InstMem_Ready = 1'b0;
    checks++; if (got_q.size() !== exp_q.size()) $display("FAIL wrap_count got %0d exp %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL wrap_deliver got %h exp %h", g, e); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] e, g;
    apply_reset();
    InstMem_Ready = 1'b1; id_stall = 1'b1;
    repeat (2) @(posedge clk);
    #1; InstMem_Ready = 1'b0;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || InstMem_Read !== 1'b0) $display("FAIL rstm_full got %b/%b exp 1/0", if_valid, InstMem_Read); else passed++;
    step(); rst = 1'b1; InstMem_Ready = 1'b1;
    @(negedge clk);
    checks++; if (InstMem_Read !== 1'b0) $display("FAIL rstm_read got %b exp 0", InstMem_Read); else passed++;
    step(); rst = 1'b0; id_stall = 1'b0;
    got_q.delete(); exp_q.delete();
    exp_q.push_back(ent(RESET_PC));
    @(negedge clk);
    checks++; if (if_valid !== 1'b0 || inst_address !== RESET_PC || if_pc !== 32'h0 || if_inst !== 32'h0)
      $display("FAIL rstm_after got %b/%h/%h/%h exp 0/%h/0/0", if_valid, inst_address, if_pc, if_inst, RESET_PC); else passed++;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== RESET_PC) $display("FAIL rstm_resume got %b/%h exp 1/%h", if_valid, if_pc, RESET_PC); else passed++;
    step(); id_stall = 1'b1; InstMem_Ready = 1'b0;
    checks++; if (got_q.size() !== exp_q.size()) $display("FAIL rstm_count got %0d exp %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL rstm_deliver got %h exp %h", g, e); else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; InstMem_Ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; id_stall = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_latency();
    test_redirect_full();
    test_redirect_empty();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
